// File: rtl/ecc_seq_pkg.sv
// Shared types, constants and elaboration helpers for the ECC command sequencer.
package ecc_seq_pkg;

  // Sequencer phases.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_LOOP  = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } seq_state_e;

  // Command index 0 is the datapath NOP.
  localparam int unsigned NOP_CMD = 0;

  // Default program layout in the datapath command ROM.
  localparam int unsigned DEF_KEY_W     = 163;
  localparam int unsigned DEF_CMD_LEN   = 6;
  localparam int unsigned DEF_CMD_LAT   = 4;
  localparam int unsigned DEF_INIT_BASE = 1;
  localparam int unsigned DEF_INIT_LEN  = 4;
  localparam int unsigned DEF_LAD0_BASE = 8;
  localparam int unsigned DEF_LAD1_BASE = 20;
  localparam int unsigned DEF_STEP_LEN  = 6;
  localparam int unsigned DEF_FIN_BASE  = 32;
  localparam int unsigned DEF_FIN_LEN   = 8;

  // Highest command index touched by a program of len entries starting at base.
  function automatic int unsigned max_cmd_idx(input int unsigned base, input int unsigned len);
    return base + len - 1;
  endfunction

  // Width of an index able to address n items (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ecc_lz_detect.sv
// Priority encoder: index of the highest set bit of the key (0 when key is 0).
module ecc_lz_detect
  import ecc_seq_pkg::*;
#(
  parameter int unsigned KEY_W = DEF_KEY_W,
  parameter int unsigned IDX_W = idx_w(KEY_W)
) (
  input  logic [KEY_W-1:0] key_i,
  output logic [IDX_W-1:0] hi_idx_c
);

  // Scan upward so the last hit is the most significant set bit.
  always_comb begin
    hi_idx_c = '0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      if (key_i[i]) hi_idx_c = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ecc_cmd_sequencer.sv
// ECC scalar-multiplication command sequencer: init, per-bit ladder, final.
// Optional build macro: ECC_SEQ_SKIP_LZ_EN (start the ladder at the key's top set bit).
module ecc_cmd_sequencer
  import ecc_seq_pkg::*;
#(
  parameter int unsigned KEY_W       = DEF_KEY_W,
  parameter int unsigned Command_len = DEF_CMD_LEN,
  parameter int unsigned CMD_LAT     = DEF_CMD_LAT,
  parameter int unsigned INIT_BASE   = DEF_INIT_BASE,
  parameter int unsigned INIT_LEN    = DEF_INIT_LEN,
  parameter int unsigned LAD0_BASE   = DEF_LAD0_BASE,
  parameter int unsigned LAD1_BASE   = DEF_LAD1_BASE,
  parameter int unsigned STEP_LEN    = DEF_STEP_LEN,
  parameter int unsigned FIN_BASE    = DEF_FIN_BASE,
  parameter int unsigned FIN_LEN     = DEF_FIN_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KEY_W-1:0]       key,
  input  logic                   abort,
  output logic [Command_len-1:0] Command,
  output logic                   cmd_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   zero_key
);

  localparam int unsigned BIT_W   = idx_w(KEY_W);
  localparam int unsigned WAIT_W  = 4;
  localparam int unsigned CMD_MAX = (1 << Command_len) - 1;

  // Reject parameter sets whose programs overflow the command index.
  if (CMD_LAT < 1 || CMD_LAT > 15) begin : g_bad_lat
    $error("CMD_LAT must be within 1..15");
  end
  if (INIT_LEN < 1 || STEP_LEN < 1 || FIN_LEN < 1) begin : g_bad_len
    $error("program lengths must be at least 1");
  end
  if (max_cmd_idx(INIT_BASE, INIT_LEN) > CMD_MAX) begin : g_bad_init
    $error("init program exceeds command index range");
  end
  if (max_cmd_idx(LAD0_BASE, STEP_LEN) > CMD_MAX) begin : g_bad_lad0
    $error("ladder-0 program exceeds command index range");
  end
  if (max_cmd_idx(LAD1_BASE, STEP_LEN) > CMD_MAX) begin : g_bad_lad1
    $error("ladder-1 program exceeds command index range");
  end
  if (max_cmd_idx(FIN_BASE, FIN_LEN) > CMD_MAX) begin : g_bad_fin
    $error("final program exceeds command index range");
  end

  seq_state_e             state_q, state_d;
  logic [Command_len-1:0] step_q, step_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [KEY_W-1:0]       key_q, key_d;
  logic                   zero_q, zero_d;
  logic [Command_len-1:0] cmd_q, cmd_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [BIT_W-1:0]       loop_first_bit;
  int unsigned            phase_len;
  int unsigned            cmd_base;
  logic                   issue;

`ifdef ECC_SEQ_SKIP_LZ_EN
  logic [BIT_W-1:0] hi_idx_c;

  ecc_lz_detect #(
    .KEY_W (KEY_W),
    .IDX_W (BIT_W)
  ) u_lz_detect (
    .key_i    (key_q),
    .hi_idx_c (hi_idx_c)
  );

  assign loop_first_bit = hi_idx_c;
`else
  assign loop_first_bit = BIT_W'(KEY_W - 1);
`endif

  // Next-state: phase sequencing, issue pacing and bit scanning.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    wait_d    = wait_q;
    bit_d     = bit_q;
    key_d     = key_q;
    zero_d    = zero_q;
    phase_len = 1;
    unique case (state_q)
      S_INIT:  phase_len = INIT_LEN;
      S_LOOP:  phase_len = STEP_LEN;
      S_FINAL: phase_len = FIN_LEN;
      default: phase_len = 1;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      step_d  = '0;
      wait_d  = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            key_d = key;
            if (key == '0) begin
              zero_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              zero_d  = 1'b0;
              state_d = S_INIT;
              step_d  = '0;
              wait_d  = '0;
              bit_d   = BIT_W'(KEY_W - 1);
            end
          end
        end
        S_INIT, S_LOOP, S_FINAL: begin
          if (wait_q == WAIT_W'(CMD_LAT - 1)) begin
            wait_d = '0;
            if (step_q == Command_len'(phase_len - 1)) begin
              step_d = '0;
              if (state_q == S_INIT) begin
                state_d = S_LOOP;
                bit_d   = loop_first_bit;
              end else if (state_q == S_LOOP) begin
                if (bit_q == '0) state_d = S_FINAL;
                else             bit_d   = bit_q - BIT_W'(1);
              end else begin
                state_d = S_DONE;
              end
            end else begin
              step_d = step_q + Command_len'(1);
            end
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state so every output is registered.
  always_comb begin
    cmd_base = NOP_CMD;
    issue    = 1'b0;
    unique case (state_d)
      S_INIT:  begin cmd_base = INIT_BASE; issue = (wait_d == '0); end
      S_LOOP:  begin cmd_base = key_d[bit_d] ? LAD1_BASE : LAD0_BASE; issue = (wait_d == '0); end
      S_FINAL: begin cmd_base = FIN_BASE; issue = (wait_d == '0); end
      default: begin cmd_base = NOP_CMD; issue = 1'b0; end
    endcase
    cmd_d   = issue ? Command_len'(cmd_base + 32'(step_d)) : Command_len'(NOP_CMD);
    valid_d = issue;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, counters, latched key and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      wait_q  <= '0;
      bit_q   <= '0;
      key_q   <= '0;
      zero_q  <= 1'b0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      key_q   <= key_d;
      zero_q  <= zero_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Command   = cmd_q;
  assign cmd_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign zero_key  = zero_q;

endmodule
